// File: rtl/return_stack.sv
// LIFO return stack; push/pop take effect at the clock edge and the top word is visible right after it.
// No backpressure: a push while full or a pop while empty is dropped and latched in a sticky error flag.
module return_stack #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] dado,
  output logic [WIDTH-1:0] saida,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_sp;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic             w_replace;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_wr_en;
  logic             w_ovf_set;
  logic             w_unf_set;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SP_FULL);
  // When full the low pointer bits are zero, so the subtraction wraps to DEPTH-1 as intended.
  assign w_top_idx = r_sp[PTR_W-1:0] - PTR_W'(1);

  // Push together with pop on a non-empty stack overwrites the top in place; on an empty stack it is a plain push.
  assign w_replace = push && pop && !w_empty;
  assign w_do_push = push && !w_replace && !w_full;
  assign w_do_pop  = pop && !push && !w_empty;
  assign w_wr_en   = w_replace || w_do_push;
  assign w_wr_idx  = w_replace ? w_top_idx : r_sp[PTR_W-1:0];

  assign w_ovf_set = push && !pop && w_full;
  assign w_unf_set = pop && !push && w_empty;

  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[w_wr_idx] <= dado;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_ONE;
    end else if (w_do_pop) begin
      r_sp <= r_sp - SP_ONE;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign saida     = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: queue-based reference models for a 32x16 and an 8x4 instance,
// checked every cycle, plus directed sequences with literal expectations.
module tb_return_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_push, a_pop, a_clr;
  logic [31:0] a_dado, a_saida;
  logic [4:0]  a_count;
  logic        a_empty, a_full, a_ovf, a_unf;

  logic        b_push, b_pop, b_clr;
  logic [7:0]  b_dado, b_saida;
  logic [2:0]  b_count;
  logic        b_empty, b_full, b_ovf, b_unf;

  return_stack #(.WIDTH(32), .DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .push(a_push), .pop(a_pop), .err_clr(a_clr), .dado(a_dado),
    .saida(a_saida), .count(a_count), .empty(a_empty), .full(a_full),
    .overflow(a_ovf), .underflow(a_unf)
  );

  return_stack #(.WIDTH(8), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .err_clr(b_clr), .dado(b_dado),
    .saida(b_saida), .count(b_count), .empty(b_empty), .full(b_full),
    .overflow(b_ovf), .underflow(b_unf)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference models: a queue whose back is the top of stack.
  logic [31:0] ma_q[$];
  bit          ma_ovf = 1'b0, ma_unf = 1'b0;
  logic [7:0]  mb_q[$];
  bit          mb_ovf = 1'b0, mb_unf = 1'b0;

  always @(posedge clk) begin
    bit so, su;
    so = 1'b0;
    su = 1'b0;
    if (rst) begin
      ma_q.delete();
      ma_ovf = 1'b0;
      ma_unf = 1'b0;
    end else begin
      if (a_push && a_pop && ma_q.size() > 0) ma_q[ma_q.size()-1] = a_dado;
      else if (a_push) begin
        if (ma_q.size() == 16) so = 1'b1;
        else ma_q.push_back(a_dado);
      end else if (a_pop) begin
        if (ma_q.size() == 0) su = 1'b1;
        else void'(ma_q.pop_back());
      end
      if (so) ma_ovf = 1'b1; else if (a_clr) ma_ovf = 1'b0;
      if (su) ma_unf = 1'b1; else if (a_clr) ma_unf = 1'b0;
    end
  end

  always @(posedge clk) begin
    bit so, su;
    so = 1'b0;
    su = 1'b0;
    if (rst) begin
      mb_q.delete();
      mb_ovf = 1'b0;
      mb_unf = 1'b0;
    end else begin
      if (b_push && b_pop && mb_q.size() > 0) mb_q[mb_q.size()-1] = b_dado;
      else if (b_push) begin
        if (mb_q.size() == 4) so = 1'b1;
        else mb_q.push_back(b_dado);
      end else if (b_pop) begin
        if (mb_q.size() == 0) su = 1'b1;
        else void'(mb_q.pop_back());
      end
      if (so) mb_ovf = 1'b1; else if (b_clr) mb_ovf = 1'b0;
      if (su) mb_unf = 1'b1; else if (b_clr) mb_unf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_saida", a_saida, (ma_q.size() > 0) ? ma_q[ma_q.size()-1] : 32'h0);
      chk("a_count", 32'(a_count), 32'(ma_q.size()));
      chk("a_empty", 32'(a_empty), 32'(ma_q.size() == 0));
      chk("a_full", 32'(a_full), 32'(ma_q.size() == 16));
      chk("a_overflow", 32'(a_ovf), 32'(ma_ovf));
      chk("a_underflow", 32'(a_unf), 32'(ma_unf));
      chk("b_saida", 32'(b_saida), (mb_q.size() > 0) ? 32'(mb_q[mb_q.size()-1]) : 32'h0);
      chk("b_count", 32'(b_count), 32'(mb_q.size()));
      chk("b_empty", 32'(b_empty), 32'(mb_q.size() == 0));
      chk("b_full", 32'(b_full), 32'(mb_q.size() == 4));
      chk("b_overflow", 32'(b_ovf), 32'(mb_ovf));
      chk("b_underflow", 32'(b_unf), 32'(mb_unf));
    end
  end

  // Steps start and end on a falling edge.
  task automatic a_step(input bit p, input bit o, input bit c, input logic [31:0] d);
    a_push = p; a_pop = o; a_clr = c; a_dado = d;
    @(posedge clk);
    @(negedge clk);
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0;
  endtask

  task automatic b_step(input bit p, input bit o, input bit c, input logic [7:0] d);
    b_push = p; b_pop = o; b_clr = c; b_dado = d;
    @(posedge clk);
    @(negedge clk);
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0;
  endtask

  task automatic do_reset(input bit with_push);
    rst = 1'b1; a_push = with_push; a_dado = 32'h77; b_push = with_push; b_dado = 8'h77;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; a_push = 1'b0; b_push = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_dado = '0;
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_dado = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_saida", a_saida, 32'h0);
    chk("rst_flags", {30'd0, a_ovf, a_unf}, 32'd0);

    a_step(1, 0, 0, 32'h11);
    chk("push1_saida", a_saida, 32'h11);
    a_step(1, 0, 0, 32'h22);
    a_step(1, 0, 0, 32'h33);
    chk("push3_count", 32'(a_count), 32'd3);
    chk("push3_saida", a_saida, 32'h33);
    a_step(0, 1, 0, 32'h0);
    chk("pop_saida", a_saida, 32'h22);
    chk("pop_count", 32'(a_count), 32'd2);

    do_reset(1'b1);
    chk("rst_push_ignored", 32'(a_count), 32'd0);
    for (int i = 0; i < 16; i++) a_step(1, 0, 0, 32'(i));
    chk("fill_full", 32'(a_full), 32'd1);
    chk("fill_saida", a_saida, 32'd15);
    a_step(1, 0, 0, 32'hDEAD);
    chk("ovf_flag", 32'(a_ovf), 32'd1);
    chk("ovf_count", 32'(a_count), 32'd16);
    chk("ovf_saida", a_saida, 32'd15);
    for (int i = 1; i <= 16; i++) begin
      a_step(0, 1, 0, 32'h0);
      chk("drain_saida", a_saida, (i < 16) ? 32'(15 - i) : 32'h0);
    end
    chk("drain_empty", 32'(a_empty), 32'd1);

    a_step(0, 0, 1, 32'h0);
    chk("clr_ovf", 32'(a_ovf), 32'd0);
    a_step(0, 1, 0, 32'h0);
    chk("unf_flag", 32'(a_unf), 32'd1);
    chk("unf_count", 32'(a_count), 32'd0);
    a_step(0, 0, 1, 32'h0);
    chk("clr_unf", 32'(a_unf), 32'd0);
    a_step(0, 1, 1, 32'h0);
    chk("unf_set_wins", 32'(a_unf), 32'd1);
    a_step(0, 0, 1, 32'h0);

    a_step(1, 0, 0, 32'h99);
    a_step(1, 0, 0, 32'hAA);
    a_step(1, 1, 0, 32'hBB);
    chk("repl_count", 32'(a_count), 32'd2);
    chk("repl_saida", a_saida, 32'hBB);
    a_step(0, 1, 0, 32'h0);
    chk("repl_pop_saida", a_saida, 32'h99);
    a_step(0, 1, 0, 32'h0);
    a_step(1, 1, 0, 32'hCC);
    chk("pp_empty_count", 32'(a_count), 32'd1);
    chk("pp_empty_saida", a_saida, 32'hCC);
    chk("pp_empty_unf", 32'(a_unf), 32'd0);
    for (int i = 0; i < 15; i++) a_step(1, 0, 0, 32'(100 + i));
    a_step(1, 1, 0, 32'hEE);
    chk("repl_full_ovf", 32'(a_ovf), 32'd0);
    chk("repl_full_saida", a_saida, 32'hEE);

    a_step(1, 0, 0, 32'h1234);
    chk("pre_rst_ovf", 32'(a_ovf), 32'd1);
    do_reset(1'b0);
    chk("midrst_count", 32'(a_count), 32'd0);
    chk("midrst_empty", 32'(a_empty), 32'd1);
    chk("midrst_flags", {30'd0, a_ovf, a_unf}, 32'd0);
    a_step(1, 0, 0, 32'h5);
    chk("post_rst_count", 32'(a_count), 32'd1);
    chk("post_rst_saida", a_saida, 32'h5);
    a_step(1, 0, 0, 32'h6);
    a_step(0, 1, 0, 32'h0);
    chk("post_rst_idx0", a_saida, 32'h5);

    b_step(1, 0, 0, 8'h11);
    b_step(1, 0, 0, 8'h22);
    b_step(1, 0, 0, 8'h33);
    chk("b_push3_count", 32'(b_count), 32'd3);
    chk("b_push3_saida", 32'(b_saida), 32'h33);
    b_step(0, 1, 0, 8'h0);
    chk("b_pop_saida", 32'(b_saida), 32'h22);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) b_step(1, 0, 0, 8'(i));
    chk("b_fill_full", 32'(b_full), 32'd1);
    chk("b_fill_count", 32'(b_count), 32'd4);
    chk("b_fill_saida", 32'(b_saida), 32'd3);
    b_step(1, 0, 0, 8'hAD);
    chk("b_ovf", 32'(b_ovf), 32'd1);
    chk("b_ovf_count", 32'(b_count), 32'd4);
    chk("b_ovf_saida", 32'(b_saida), 32'd3);
    for (int i = 1; i <= 4; i++) begin
      b_step(0, 1, 0, 8'h0);
      chk("b_drain_saida", 32'(b_saida), (i < 4) ? 32'(3 - i) : 32'h0);
    end
    chk("b_drain_empty", 32'(b_empty), 32'd1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, minimum 2.
REQ-003 Derived PTR_W = log2(DEPTH), pointer width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port push  input  1  push request, sampled at rising edge.
REQ-007 Port pop  input  1  pop request, sampled at rising edge.
REQ-008 Port err_clr  input  1  clears sticky error flags.
REQ-009 Port dado  input  WIDTH  word to push.
REQ-010 Port saida  output  WIDTH  current top-of-stack word.
REQ-011 Port count  output  PTR_W+1  number of valid entries, 0..DEPTH.
REQ-012 Port empty  output  1  high when count == 0.
REQ-013 Port full  output  1  high when count == DEPTH.
REQ-014 Port overflow  output  1  sticky: push attempted while full.
REQ-015 Port underflow  output  1  sticky: pop attempted while empty.

Function
REQ-016 Storage: DEPTH x WIDTH register array plus stack pointer sp (= count); entry sp-1 is top.
REQ-017 saida SHALL be combinational from registered state: mem[sp-1] when count > 0, all zeros when empty.
REQ-018 Latency: word pushed at edge N SHALL appear on saida after edge N; pop at edge N exposes previous entry after edge N.
REQ-019 Push only, not full: mem[sp] <= dado; count +1.
REQ-020 Push only, full: no write, count unchanged, overflow <= 1; existing entries untouched.
REQ-021 Pop only, not empty: count -1; array contents not cleared.
REQ-022 Pop only, empty: count unchanged, underflow <= 1.
REQ-023 Push and pop, count > 0: replace top, mem[sp-1] <= dado, count unchanged, no error flag even when full.
REQ-024 Push and pop, empty: behave as push only; underflow NOT set.
REQ-025 Neither asserted: no state change.
REQ-026 empty and full SHALL be decoded from count, never independently stored, so they are mutually exclusive.
REQ-027 Sticky flags hold until err_clr or rst; err_clr in the same cycle as a new error: flag remains 1 (set wins).
REQ-028 count arithmetic SHALL never wrap: no increment past DEPTH, no decrement below 0.

Reset
REQ-029 rst high at rising edge: count <= 0, overflow <= 0, underflow <= 0; push/pop in that cycle ignored.
REQ-030 Array contents not reset; saida reads 0 after reset because empty.
REQ-031 Reset mid-sequence (e.g. stack full) SHALL discard all entries in one cycle; next push lands at index 0.

Verification
REQ-032 Reset, push 0x00000011, 0x00000022, 0x00000033 -> count 3, saida 0x33; pop -> saida 0x22, count 2.
REQ-033 DEPTH=16: push 16 words 0..15 -> full=1, saida 15; 17th push 0xDEAD -> overflow=1, count 16, saida 15; pop 16 times -> values 14..0 then empty=1, saida 0.
REQ-034 Empty, pop -> underflow=1, count 0; err_clr -> underflow=0; err_clr with pop on empty same cycle -> underflow stays 1.
REQ-035 Count 2 top 0xAA, push+pop with dado 0xBB -> count 2, saida 0xBB, then pop -> previous entry; push+pop when empty with 0xCC -> count 1, saida 0xCC, underflow 0.
REQ-036 Full stack with overflow=1, assert rst -> count 0, empty 1, both flags 0; push 0x5 -> count 1, saida 0x5.
REQ-037 Repeat REQ-032/033 with WIDTH=8, DEPTH=4 -> full after 4 pushes, count width 3 bits, no wrap.
